// File: rtl/life_pkg.sv
// ============================================================================
// Module  : life_pkg
// Brief   : Shared constants, state encoding and LFSR step for the Life sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package life_pkg;

    localparam int          ADDR_W_DEF = 12;
    localparam int          CELLS_DEF  = 4096;
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;

    typedef enum logic [1:0] {
        SEED      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        WAIT_SWAP = 2'd3
    } seq_state_t;

    // Right-shifting Galois step; a nonzero state never maps to zero.
    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        lfsr_next = q[0] ? ((q >> 1) ^ LFSR_TAPS) : (q >> 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/life_seq_lfsr16.sv
// ============================================================================
// Module  : lfsr16
// Brief   : 16-bit Galois LFSR, loads the seed on reset and steps on adv.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr16 #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        adv,
    output logic [15:0] q
);
    import life_pkg::*;

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= LFSR_SEED;
        end else if (adv) begin
            q <= lfsr_next(q);
        end
    end

endmodule

`default_nettype wire

// File: rtl/life_seq.sv
// ============================================================================
// Module  : life_seq
// Brief   : Life generation sequencer: seeds the active buffer, starts one
//           generation at a time and swaps buffers only at vblank.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module life_seq #(
    parameter int          ADDR_W           = life_pkg::ADDR_W_DEF,
    parameter int          CELLS            = life_pkg::CELLS_DEF,
    parameter int          FRAMES_PER_GEN   = 3,
    parameter logic [15:0] LFSR_SEED        = 16'hACE1,
    parameter int          DENSITY          = 5,
    parameter bit          VSYNC_ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vsync,
    input  logic              gen_done,
    input  logic              pause,
    input  logic              step,
    input  logic              reseed,
    output logic              activebuf,
    output logic              gen_start,
    output logic              seeding,
    output logic              seed_we,
    output logic [ADDR_W-1:0] seed_addr,
    output logic              seed_din,
    output logic [15:0]       gen_count,
    output logic              overrun
);
    import life_pkg::*;

    localparam int                FC_W         = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;
    localparam logic [FC_W-1:0]   C_FRAME_LAST = FC_W'(FRAMES_PER_GEN - 1);
    localparam logic [ADDR_W-1:0] C_SEED_LAST  = ADDR_W'(CELLS - 1);

    seq_state_t        r_state;
    logic              r_vs_q;
    logic [FC_W-1:0]   r_frame_cnt;
    logic              r_step_pend;
    logic [ADDR_W-1:0] r_seed_idx;

    logic [15:0]       w_lfsr;
    logic              w_vedge;
    logic              w_target;
    logic              w_seed_fire;
    logic              w_seed_bit;
    logic              w_lfsr_adv;
    logic [ADDR_W-1:0] w_seed_addr;
    logic              w_lfsr_unused;

    assign w_vedge     = VSYNC_ACTIVE_LOW ? (r_vs_q & ~vsync) : (~r_vs_q & vsync);
    assign w_target    = w_vedge && (r_frame_cnt == C_FRAME_LAST);
    // A reseed performs the address-0 write in the very cycle it is taken.
    assign w_seed_fire = reseed || (r_state == SEED);
    assign w_seed_addr = reseed ? '0 : r_seed_idx;
    assign w_seed_bit  = (32'(w_lfsr[3:0]) < 32'(DENSITY));
    assign w_lfsr_adv  = ~rst & w_seed_fire;
    assign w_lfsr_unused = ^w_lfsr[15:4];

    lfsr16 #(
        .LFSR_SEED (LFSR_SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .adv (w_lfsr_adv),
        .q   (w_lfsr)
    );

    always_ff @(posedge clk) begin
        r_vs_q <= vsync;
        if (rst) begin
            r_state     <= SEED;
            activebuf   <= 1'b0;
            gen_start   <= 1'b0;
            seeding     <= 1'b0;
            seed_we     <= 1'b0;
            seed_addr   <= '0;
            seed_din    <= 1'b0;
            gen_count   <= '0;
            overrun     <= 1'b0;
            r_frame_cnt <= '0;
            r_step_pend <= 1'b0;
            r_seed_idx  <= '0;
        end else begin
            gen_start <= 1'b0;
            seeding   <= 1'b0;
            seed_we   <= 1'b0;
            if (reseed) begin
                gen_count   <= '0;
                overrun     <= 1'b0;
                r_frame_cnt <= '0;
                r_step_pend <= 1'b0;
            end else begin
                if (w_vedge && (r_frame_cnt != C_FRAME_LAST)) begin
                    r_frame_cnt <= r_frame_cnt + FC_W'(1);
                end
                if (pause && step) begin
                    r_step_pend <= 1'b1;
                end
                case (r_state)
                    START: begin
                        gen_start <= 1'b1;
                        r_state   <= WAIT_DONE;
                    end
                    WAIT_DONE: begin
                        if (w_target) begin
                            overrun <= 1'b1;
                        end
                        if (gen_done) begin
                            r_state <= WAIT_SWAP;
                        end
                    end
                    WAIT_SWAP: begin
                        // Swap clears the step request even if step is re-asserted now.
                        if (w_target && (!pause || r_step_pend)) begin
                            activebuf   <= ~activebuf;
                            gen_count   <= gen_count + 16'd1;
                            r_frame_cnt <= '0;
                            r_step_pend <= 1'b0;
                            r_state     <= START;
                        end
                    end
                    default: ;
                endcase
            end
            if (w_seed_fire) begin
                seeding    <= 1'b1;
                seed_we    <= 1'b1;
                seed_addr  <= w_seed_addr;
                seed_din   <= w_seed_bit;
                r_seed_idx <= w_seed_addr + ADDR_W'(1);
                r_state    <= (w_seed_addr == C_SEED_LAST) ? START : SEED;
            end
        end
    end

endmodule

`default_nettype wire
